// File: rtl/fifo_stim_writer.sv
// ---------------------------------------------------------------------------
// fifo_stim_writer
//
// Purpose:
//   Stimulus generator for the write side of a FIFO. On a start request it
//   writes a burst of num_words incrementing data words, optionally spacing
//   the writes by gap_cyc idle cycles, and honours backpressure from wr_full.
//   The data sequence is continuous across bursts and wraps modulo
//   2^DAT_BIT. A running total of accepted writes is kept since reset.
//
// Parameters:
//   DAT_BIT  - write data width
//   CNT_BIT  - width of the word count, stall count and total count
//
// Ports:
//   wr_clk      in   single clock, rising edge
//   wr_rst_n    in   asynchronous active-low reset
//   start       in   burst request pulse (honoured only in IDLE)
//   abort       in   terminate the burst in progress
//   num_words   in   burst length, sampled when start is accepted
//   gap_cyc     in   idle cycles after each non-final write, sampled on start
//   wr_full     in   FIFO full flag (write domain)
//   wr_en       out  FIFO write strobe
//   wr_data     out  FIFO write data (current sequence value)
//   busy        out  burst in progress (WRITE or GAP)
//   done        out  one-cycle pulse when a burst completes
//   stall_cnt   out  cycles the current/last burst was blocked by wr_full
//   wr_total    out  accepted writes since reset (wraps)
//   dbg_state   out  FSM state (0=IDLE 1=WRITE 2=GAP 3=DONE)
//
// Handshake:
//   A write is accepted in every cycle where wr_en=1. wr_en is raised only
//   in WRITE when wr_full=0 and abort=0; the FIFO must take the word in that
//   same cycle. There is no other handshake on this block.
//
// Build option:
//   FIFO_STIM_TRACE_EN - when defined, adds simulation-only trace messages
//   for each accepted write, each burst completion, and a warning when
//   wr_full has been held for 256 consecutive WRITE cycles. Port behaviour
//   is identical with or without it.
// ---------------------------------------------------------------------------
module fifo_stim_writer #(
  parameter int DAT_BIT = 8,
  parameter int CNT_BIT = 16
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_BIT-1:0] num_words,
  input  logic [3:0]         gap_cyc,
  input  logic               wr_full,
  output logic               wr_en,
  output logic [DAT_BIT-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_BIT-1:0] stall_cnt,
  output logic [CNT_BIT-1:0] wr_total,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DAT_BIT-1:0] SEQ_ONE = DAT_BIT'(1);
  localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic [DAT_BIT-1:0] r_seq;
  logic [CNT_BIT-1:0] r_words_left;
  logic [3:0]         r_gap;
  logic [3:0]         r_gap_cnt;
  logic [CNT_BIT-1:0] r_stall_cnt;
  logic [CNT_BIT-1:0] r_wr_total;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  state_t w_next_state;
  logic   w_start_acc;
  logic   w_wr_acc;
  logic   w_stall;
  logic   w_last;
  logic   w_enter_gap;

  // abort in IDLE also blocks start, so start+abort leaves the FSM idle.
  assign w_start_acc = (r_state == ST_IDLE) && start && !abort;

  // abort has priority over the write strobe: no word leaves in an abort cycle.
  assign w_wr_acc    = (r_state == ST_WRITE) && !wr_full && !abort;
  assign w_stall     = (r_state == ST_WRITE) &&  wr_full && !abort;
  assign w_last      = (r_words_left == CNT_ONE);
  assign w_enter_gap = w_wr_acc && !w_last && (r_gap != 4'd0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    wr_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          // A zero-length burst goes straight to DONE so the caller still
          // sees a completion pulse.
          if (num_words == '0) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        busy  = 1'b1;
        wr_en = w_wr_acc;
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (w_wr_acc) begin
          if (w_last) begin
            w_next_state = ST_DONE;
          end else if (r_gap != 4'd0) begin
            w_next_state = ST_GAP;
          end else begin
            w_next_state = ST_WRITE;
          end
        end
        // wr_full with no abort: hold in WRITE.
      end

      ST_GAP: begin
        busy = 1'b1;
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (r_gap_cnt == 4'd0) begin
          w_next_state = ST_WRITE;
        end
      end

      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequence value: persists across bursts, wraps naturally.
  // -------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_seq <= '0;
    end else if (w_wr_acc) begin
      r_seq <= r_seq + SEQ_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Burst parameters: words remaining and latched gap length
  // -------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_words_left <= '0;
      r_gap        <= 4'd0;
    end else if (w_start_acc) begin
      r_words_left <= num_words;
      r_gap        <= gap_cyc;
    end else if (w_wr_acc) begin
      r_words_left <= r_words_left - CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Gap counter. Loaded with gap-1 on entry so that GAP occupies exactly
  // r_gap cycles: it leaves when the counter reads zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_gap_cnt <= 4'd0;
    end else if (w_enter_gap) begin
      r_gap_cnt <= r_gap - 4'd1;
    end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
      r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Stall counter: cleared on each accepted start, saturating.
  // -------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Total accepted writes since reset, wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_wr_total <= '0;
    end else if (w_wr_acc) begin
      r_wr_total <= r_wr_total + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign wr_data   = r_seq;
  assign stall_cnt = r_stall_cnt;
  assign wr_total  = r_wr_total;
  assign dbg_state = r_state;

  // -------------------------------------------------------------------------
  // Optional simulation trace
  // -------------------------------------------------------------------------
`ifdef FIFO_STIM_TRACE_EN
  // Consecutive WRITE cycles with wr_full high; saturates so the warning
  // fires once per blocked stretch.
  logic [8:0] r_full_run;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_full_run <= '0;
    end else begin
      if ((r_state == ST_WRITE) && wr_full) begin
        if (r_full_run != 9'h1FF) begin
          r_full_run <= r_full_run + 9'd1;
        end
        if (r_full_run == 9'd255) begin
          $display("%0t fifo_stim_writer: warning, wr_full held for 256 WRITE cycles (seq=%0d words_left=%0d)",
                   $time, r_seq, r_words_left);
        end
      end else begin
        r_full_run <= '0;
      end

      if (w_wr_acc) begin
        $display("%0t fifo_stim_writer: write seq=%0d words_left=%0d",
                 $time, r_seq, r_words_left);
      end

      if (r_state == ST_DONE) begin
        $display("%0t fifo_stim_writer: burst done seq=%0d words_left=%0d",
                 $time, r_seq, r_words_left);
      end
    end
  end
`else
  // Trace disabled: no additional logic.
`endif

endmodule
